icache_data_ctrl: RTL and testbench

Direct-mapped instruction-cache controller that sequences the 32×64-bit, 1W/1R icache data SRAM. It holds the tag/valid array in flops, services CPU fetches with a valid/ready handshake, and refills misses from the memory side one 64-bit line per miss. It sits between the fetch stage, the next-level memory interface and the data SRAM macro, and owns every SRAM control pin.

---
 rtl/icache_data_ctrl.sv | 140 ++++++++++++++
 tb/tb_icache_data_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_data_ctrl.sv
// icache_data_ctrl: direct-mapped icache controller driving a 1W/1R data SRAM.
// Tags and valid bits live in flops; misses refill one line from memory.
module icache_data_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 5,
    parameter int DATA_WIDTH  = 64,
    parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_valid,
    output logic                   fetch_ready,
    input  logic [ADDR_WIDTH-1:0]  fetch_addr,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_WIDTH-1:0]  resp_data,
    input  logic                   flush,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic                   mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]  mem_resp_data,
    output logic                   sram_csb0,
    output logic [INDEX_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0]  sram_din0,
    output logic                   sram_csb1,
    output logic [INDEX_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0]  sram_dout1
);

    localparam int LINES = 1 << INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        RESP
    } state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LINES-1:0]       valid_q;
    logic [TAG_WIDTH-1:0]   tag_q [LINES];
    logic                   flush_pend;

    logic [INDEX_WIDTH-1:0] idx_q;
    logic [TAG_WIDTH-1:0]   tag_in;
    logic                   accept;
    logic                   beat;
    logic                   hit;

    assign idx_q  = addr_q[INDEX_WIDTH+2:3];
    assign tag_in = addr_q[ADDR_WIDTH-1:INDEX_WIDTH+3];

    assign fetch_ready = (state == IDLE) && !flush && !flush_pend;
    assign accept      = fetch_valid && fetch_ready;
    assign beat        = (state == MISS_WAIT) && mem_resp_valid;
    assign hit         = valid_q[idx_q] && (tag_q[idx_q] == tag_in);

    // SRAM pins: read only on accept, write only on the refill beat
    always_comb begin
        sram_csb1  = !accept;
        sram_addr1 = accept ? fetch_addr[INDEX_WIDTH+2:3] : '0;
        sram_csb0  = !beat;
        sram_addr0 = beat ? idx_q : '0;
        sram_din0  = beat ? mem_resp_data : '0;
    end

    // Tag array needs no reset: a tag is only read behind its valid bit
    always_ff @(posedge clk) begin
        if (beat) begin
            tag_q[idx_q] <= tag_in;
        end
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            valid_q       <= '0;
            flush_pend    <= 1'b0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
        end else begin
            if (flush) begin
                flush_pend <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (flush_pend) begin
                        valid_q <= '0;
                        if (!flush) begin
                            flush_pend <= 1'b0;
                        end
                    end else if (accept) begin
                        addr_q <= fetch_addr;
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_data  <= sram_dout1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= addr_q & ~ADDR_WIDTH'(7);
                        state         <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (mem_resp_valid) begin
                        valid_q[idx_q] <= 1'b1;
                        resp_data      <= mem_resp_data;
                        resp_valid     <= 1'b1;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_data_ctrl.sv
// tb_icache_data_ctrl: randomized scoreboard bench with an SRAM and memory model.
// Expected lines come from a tag/valid reference of the cache and a line table.
module tb_icache_data_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_data;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;
    logic        sram_csb0;
    logic [4:0]  sram_addr0;
    logic [63:0] sram_din0;
    logic        sram_csb1;
    logic [4:0]  sram_addr1;
    logic [63:0] sram_dout1 = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issued = 0;
    int txn_done = 0;
    bit auto_mem = 1'b1;
    bit rr_force = 1'b1;
    bit rr_val = 1'b1;

    always #5 clk = ~clk;

    icache_data_ctrl dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_addr(fetch_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .sram_csb0(sram_csb0), .sram_addr0(sram_addr0),
        .sram_din0(sram_din0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1),
        .sram_dout1(sram_dout1)
    );

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    logic [63:0] over [bit [31:0]];

    function automatic logic [63:0] line_data(input logic [31:0] a);
        bit [31:0] la;
        la = {a[31:3], 3'b000};
        if (over.exists(la)) return over[la];
        return {la ^ 32'hC0DE_5EED, (la * 32'h9E37_79B1) ^ 32'h0BAD_F00D};
    endfunction

    // reference cache state
    bit          mv [32];
    logic [23:0] mt [32];

    typedef struct packed {
        logic [63:0] data;
        logic        miss;
    } exp_t;
    exp_t sb [$];

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mv[i] = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // behavioural SRAM: sample at posedge, act at negedge
    initial begin
        logic [63:0] mem [32];
        logic        rd_en, wr_en;
        logic [4:0]  rd_a, wr_a;
        logic [63:0] wr_d;
        for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
        forever begin
            @(posedge clk);
            rd_en = !sram_csb1; rd_a = sram_addr1;
            wr_en = !sram_csb0; wr_a = sram_addr0; wr_d = sram_din0;
            @(negedge clk);
            if (wr_en) mem[wr_a] = wr_d;
            if (rd_en) sram_dout1 = mem[rd_a];
        end
    end

    // memory responder with random delays and stray beats
    initial begin
        int phase = 0;
        int dly = 0;
        logic [31:0] ra = '0;
        forever begin
            @(posedge clk); #1;
            if (!auto_mem || rst) begin
                phase = 0;
                continue;
            end
            mem_req_ready = 1'b0;
            mem_resp_valid = 1'b0;
            case (phase)
                0: begin
                    if (mem_req_valid) begin
                        dly = $urandom_range(0, 3);
                        phase = 1;
                    end else if ($urandom_range(0, 5) == 0) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data = {$urandom, $urandom};
                    end
                end
                1: begin
                    if (dly == 0) begin
                        mem_req_ready = 1'b1;
                        ra = mem_req_addr;
                        dly = $urandom_range(0, 4);
                        phase = 2;
                    end else dly--;
                end
                default: begin
                    if (dly == 0) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data = line_data(ra);
                        phase = 0;
                    end else dly--;
                end
            endcase
        end
    end

    initial forever begin
        @(posedge clk); #1;
        resp_ready = rr_force ? rr_val : ($urandom_range(0, 2) != 0);
    end

    // monitor: timing, SRAM pin and scoreboard checks
    initial begin
        bit waiting = 0, req_seen = 0, resp_seen = 0, prev_rv = 0;
        int acc_cyc = 0, beat_cyc = -1;
        logic [31:0] cur = '0;
        logic [63:0] prev_rd = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                waiting = 0; req_seen = 0; resp_seen = 0; prev_rv = 0;
                continue;
            end
            if (mem_resp_valid) begin
                if (waiting) begin
                    chk(!sram_csb0, "beat_csb0", 64'(sram_csb0), 0);
                    chk(sram_addr0 == cur[7:3], "beat_addr0",
                        64'(sram_addr0), 64'(cur[7:3]));
                    chk(sram_din0 == mem_resp_data, "beat_din0",
                        sram_din0, mem_resp_data);
                    beat_cyc = cyc;
                    waiting = 0;
                end else begin
                    chk(sram_csb0, "stray_beat_write", 64'(sram_csb0), 1);
                end
            end
            if (mem_req_valid && mem_req_ready) waiting = 1;
            if (mem_req_valid && !req_seen) begin
                req_seen = 1;
                chk(cyc == acc_cyc + 2, "req_cycle",
                    64'(cyc - acc_cyc), 2);
                chk(mem_req_addr == {cur[31:3], 3'b000}, "req_addr",
                    64'(mem_req_addr), 64'({cur[31:3], 3'b000}));
            end
            if (prev_rv) begin
                chk(resp_valid, "resp_valid_hold", 64'(resp_valid), 1);
                chk(resp_data == prev_rd, "resp_data_hold",
                    resp_data, prev_rd);
            end
            if (resp_valid) begin
                chk(!fetch_ready, "ready_in_resp", 64'(fetch_ready), 0);
                if (!resp_seen) begin
                    resp_seen = 1;
                    if (req_seen)
                        chk(cyc == beat_cyc + 1, "miss_resp_cycle",
                            64'(cyc - beat_cyc), 1);
                    else
                        chk(cyc == acc_cyc + 2, "hit_resp_cycle",
                            64'(cyc - acc_cyc), 2);
                end
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk(0, "unexpected_resp", resp_data, 0);
                end else begin
                    e = sb.pop_front();
                    chk(resp_data == e.data, "resp_data", resp_data, e.data);
                    chk(req_seen == e.miss, "hit_miss",
                        64'(req_seen), 64'(e.miss));
                end
                txn_done++;
                prev_rv = 0;
            end else begin
                prev_rv = resp_valid;
            end
            prev_rd = resp_data;
            if (fetch_valid && fetch_ready) begin
                acc_cyc = cyc; cur = fetch_addr;
                req_seen = 0; resp_seen = 0; beat_cyc = -1;
                chk(!sram_csb1, "accept_csb1", 64'(sram_csb1), 0);
                chk(sram_addr1 == fetch_addr[7:3], "accept_addr1",
                    64'(sram_addr1), 64'(fetch_addr[7:3]));
            end
        end
    end

    task automatic issue(input logic [31:0] a);
        int n = 0;
        bit hit;
        @(posedge clk); #1;
        fetch_valid = 1'b1;
        fetch_addr = a;
        forever begin
            @(negedge clk);
            if (fetch_ready) break;
            n++;
            if (n > 50) break;
        end
        chk(fetch_ready, "accept_timeout", 64'(fetch_ready), 1);
        if (fetch_ready) begin
            hit = mv[a[7:3]] && (mt[a[7:3]] == a[31:8]);
            sb.push_back('{data: line_data(a), miss: !hit});
            mv[a[7:3]] = 1'b1;
            mt[a[7:3]] = a[31:8];
            issued++;
        end
        @(posedge clk); #1;
        fetch_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (txn_done < issued && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(txn_done >= issued, "txn_timeout", 64'(txn_done), 64'(issued));
    endtask

    task automatic fetch(input logic [31:0] a);
        issue(a);
        wait_done();
    endtask

    task automatic flush_pulse();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
    endtask

    task automatic reset_checks();
        chk(!resp_valid, "rst_resp_valid", 64'(resp_valid), 0);
        chk(resp_data == 0, "rst_resp_data", resp_data, 0);
        chk(!mem_req_valid, "rst_mem_req_valid", 64'(mem_req_valid), 0);
        chk(mem_req_addr == 0, "rst_mem_req_addr", 64'(mem_req_addr), 0);
        chk(sram_csb0 && sram_csb1, "rst_csb",
            64'({sram_csb0, sram_csb1}), 3);
        chk(sram_addr0 == 0 && sram_addr1 == 0 && sram_din0 == 0,
            "rst_sram_pins", sram_din0, 0);
        chk(fetch_ready, "rst_fetch_ready", 64'(fetch_ready), 1);
    endtask

    initial begin
        int n;
        int r;
        logic [31:0] a;
        over[32'h0000_0108] = 64'hDEAD_BEEF_0123_4567;
        over[32'h0000_1108] = 64'h1111_2222_3333_4444;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks();
        @(posedge clk); #1 rst = 1'b0;

        fetch(32'h0000_0108);
        fetch(32'h0000_010C);
        fetch(32'h0000_1108);
        fetch(32'h0000_0108);

        fork
            issue(32'h0000_2108);
            begin
                repeat (4) @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk); #1 flush = 1'b0;
            end
        join
        wait_done();
        model_clear();
        fetch(32'h0000_2108);
        flush_pulse();
        model_clear();

        rr_val = 1'b0;
        issue(32'h0000_010C);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk(resp_valid, "bp_resp_valid", 64'(resp_valid), 1);
            chk(resp_data == 64'hDEAD_BEEF_0123_4567, "bp_resp_data",
                resp_data, 64'hDEAD_BEEF_0123_4567);
            chk(!fetch_ready, "bp_fetch_ready", 64'(fetch_ready), 0);
        end
        @(posedge clk); #1 rr_val = 1'b1;
        wait_done();

        auto_mem = 1'b0;
        issue(32'h0000_3108);
        n = 0;
        while (!mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(mem_req_valid, "manual_req", 64'(mem_req_valid), 1);
        @(posedge clk); #1 mem_req_ready = 1'b1;
        @(posedge clk); #1 mem_req_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_checks();
        model_clear();
        issued = txn_done;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = line_data(32'h0000_3108);
        @(posedge clk); #1 mem_resp_valid = 1'b0;
        @(negedge clk);
        chk(!resp_valid && !mem_req_valid, "late_beat_ignored",
            64'({resp_valid, mem_req_valid}), 0);
        auto_mem = 1'b1;
        fetch(32'h0000_3108);

        rr_force = 1'b0;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 31) << 3)
              | $urandom_range(0, 7);
            if (r == 0) begin
                flush_pulse();
                model_clear();
            end else if (r == 1) begin
                fork
                    issue(a);
                    begin
                        repeat ($urandom_range(2, 6)) @(posedge clk);
                        #1 flush = 1'b1;
                        @(posedge clk); #1 flush = 1'b0;
                    end
                join
                wait_done();
                model_clear();
            end else begin
                fetch(a);
            end
        end
        rr_force = 1'b1;
        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
